// File: rtl/m_axi_lite_cmd.sv
// m_axi_lite_cmd
//   AXI4-Lite master that turns a single-beat command/response handshake into
//   one AXI4-Lite write (AW + W + B) or read (AR + R) transaction at a time.
//   The slave's response code and read data are returned on a response port
//   that holds its value until consumed.
//
// Ports
//   m_axi_aclk, m_axi_areset : clock and synchronous active-high reset
//   cmd_*                    : command in (valid/ready, write flag, address,
//                              write data, write strobes)
//   rsp_*                    : response out (valid/ready, read data, resp code,
//                              write echo)
//   m_axi_aw*/w*/b*          : AXI4-Lite write address, data, response
//   m_axi_ar*/r*             : AXI4-Lite read address, data
module m_axi_lite_cmd #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_write,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  write_q, write_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  ar_done_q, ar_done_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;

  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
  logic aw_done_now, w_done_now, ar_done_now;

  assign cmd_hs = cmd_valid & cmd_ready_q;
  assign aw_hs  = awvalid_q & m_axi_awready;
  assign w_hs   = wvalid_q & m_axi_wready;
  assign b_hs   = bready_q & m_axi_bvalid;
  assign ar_hs  = arvalid_q & m_axi_arready;
  assign r_hs   = rready_q & m_axi_rvalid;
  assign rsp_hs = rsp_valid_q & rsp_ready;

  // "Done" includes a handshake happening on this edge so that bready/rready
  // can rise in the very next cycle.
  assign aw_done_now = aw_done_q | aw_hs;
  assign w_done_now  = w_done_q | w_hs;
  assign ar_done_now = ar_done_q | ar_hs;

  // State register and all output/datapath flops
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      ar_done_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      write_q     <= write_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      ar_done_q   <= ar_done_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_hs) state_d = cmd_write ? WR : RD;
      WR:   if (b_hs)   state_d = RSP;
      RD:   if (r_hs)   state_d = RSP;
      RSP:  if (rsp_hs) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Output / datapath next values; every output is taken from a flop so no
  // valid ever depends combinationally on its ready.
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ar_done_d = ar_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    bready_d  = 1'b0;
    rready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          awvalid_d = cmd_write;
          wvalid_d  = cmd_write;
          arvalid_d = ~cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          ar_done_d = 1'b0;
        end
      end
      WR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // B is only offered once both AW and W are finished; an early
        // bvalid simply waits.
        bready_d = ~b_hs & aw_done_now & w_done_now;
        if (b_hs) begin
          rdata_d = '0;
          resp_d  = m_axi_bresp;
        end
      end
      RD: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          ar_done_d = 1'b1;
        end
        rready_d = ~r_hs & ar_done_now;
        if (r_hs) begin
          rdata_d = m_axi_rdata;
          resp_d  = m_axi_rresp;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready_d = (state_d == IDLE);
  assign rsp_valid_d = (state_d == RSP);

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_write     = write_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_m_axi_lite_cmd.sv
// Testbench for m_axi_lite_cmd: a register-bank AXI4-Lite slave model with
// per-channel ready/valid delays, and a scoreboard of expected responses.
module tb_m_axi_lite_cmd;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready;
  logic [DW-1:0] m_axi_wdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_wvalid, m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid, m_axi_bready;
  logic          m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  m_axi_lite_cmd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // Slave model configuration (written by the stimulus)
  int            aw_dly = 1, w_dly = 1, b_dly = 0, ar_dly = 1, r_dly = 0;
  bit            b_early = 1'b0, r_force = 1'b0;
  logic [1:0]    b_resp_f = 2'b00, r_resp_f = 2'b00;
  logic [DW-1:0] r_data_f = '0;

  // Slave model state
  logic [DW-1:0] mem [16] = '{default: '0};
  bit            aw_got, w_got, ar_got, mem_done;
  bit            aw_hs_p, w_hs_p, ar_hs_p, b_hs_p, r_hs_p;
  int            aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic [AW-1:0] bfm_awaddr, bfm_araddr;
  logic [DW-1:0] bfm_wdata;
  logic [SW-1:0] bfm_wstrb;
  int            b_cnt = 0, r_cnt = 0, viol = 0;

  // The slave acts on the falling edge: DUT outputs are settled, and any
  // valid&&ready it sees here becomes a handshake on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
      aw_got = 0; w_got = 0; ar_got = 0; mem_done = 0;
      aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0; b_hs_p = 0; r_hs_p = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    end else begin
      // A valid must be gone the cycle after its handshake.
      if (aw_hs_p && m_axi_awvalid) viol++;
      if (w_hs_p && m_axi_wvalid) viol++;
      if (ar_hs_p && m_axi_arvalid) viol++;
      aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0;
      if (b_hs_p) begin
        m_axi_bvalid = 1'b0; b_cnt++;
        aw_got = 0; w_got = 0; mem_done = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; b_hs_p = 0;
      end
      if (r_hs_p) begin
        m_axi_rvalid = 1'b0; r_cnt++;
        ar_got = 0; ar_wait = 0; r_wait = 0; r_hs_p = 0;
      end
      // B channel (uses AW/W completion from earlier cycles)
      if (!m_axi_bvalid && ((aw_got && w_got) || (b_early && (aw_got || w_got)))) begin
        if (b_wait >= b_dly) begin m_axi_bvalid = 1'b1; m_axi_bresp = b_resp_f; end
        else b_wait++;
      end
      if (m_axi_bready && !(aw_got && w_got)) viol++;
      if (m_axi_bvalid && m_axi_bready) b_hs_p = 1;
      // R channel
      if (!m_axi_rvalid && ar_got) begin
        if (r_wait >= r_dly) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = r_force ? r_data_f : mem[bfm_araddr[5:2]];
          m_axi_rresp  = r_force ? r_resp_f : 2'b00;
        end else r_wait++;
      end
      if (m_axi_rready && !ar_got) viol++;
      if (m_axi_rvalid && m_axi_rready) r_hs_p = 1;
      // AW / W / AR ready generation
      m_axi_awready = 1'b0;
      if (m_axi_awvalid && !aw_got) begin
        if (aw_wait >= aw_dly) begin
          m_axi_awready = 1'b1; aw_got = 1; aw_hs_p = 1; bfm_awaddr = m_axi_awaddr;
        end else aw_wait++;
      end
      m_axi_wready = 1'b0;
      if (m_axi_wvalid && !w_got) begin
        if (w_wait >= w_dly) begin
          m_axi_wready = 1'b1; w_got = 1; w_hs_p = 1;
          bfm_wdata = m_axi_wdata; bfm_wstrb = m_axi_wstrb;
        end else w_wait++;
      end
      m_axi_arready = 1'b0;
      if (m_axi_arvalid && !ar_got) begin
        if (ar_wait >= ar_dly) begin
          m_axi_arready = 1'b1; ar_got = 1; ar_hs_p = 1; bfm_araddr = m_axi_araddr;
        end else ar_wait++;
      end
      if (aw_got && w_got && !mem_done) begin
        for (int i = 0; i < SW; i++)
          if (bfm_wstrb[i]) mem[bfm_awaddr[5:2]][8*i +: 8] = bfm_wdata[8*i +: 8];
        mem_done = 1;
      end
    end
  end

  typedef struct {
    logic          wr;
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one command (called on a falling edge), wait for its response,
  // optionally stall rsp_ready for 'hold' cycles, then consume it.
  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [SW-1:0] ws, input logic [1:0] eresp,
                        input logic [DW-1:0] erd, input int exp_lat, input int hold);
    exp_t e, got;
    int   n;
    e.wr = wr; e.resp = eresp; e.rdata = wr ? '0 : erd;
    sb.push_back(e);
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_seen", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    chk("rsp_valid_seen", rsp_valid, 1);
    if (exp_lat > 0) chk("latency", n, exp_lat);
    got = sb.pop_front();
    chk("rsp_write", rsp_write, got.wr);
    chk("rsp_resp", rsp_resp, got.resp);
    chk("rsp_rdata", rsp_rdata, got.rdata);
    for (int i = 0; i < hold; i++) begin
      // A command offered while busy must be ignored.
      if (i == 1) begin
        cmd_write = 1'b1; cmd_addr = 6'h20; cmd_wdata = '1; cmd_wstrb = '1; cmd_valid = 1'b1;
      end
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, got.rdata);
      chk("hold_rsp_resp", rsp_resp, got.resp);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_axi_idle", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_released", rsp_valid, 0);
    chk("cmd_ready_after_rsp", cmd_ready, 1);
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_addr", {m_axi_awaddr, m_axi_araddr, m_axi_wstrb}, 0);
    chk("rst_wdata", m_axi_wdata, 0);
    chk("prot", {m_axi_awprot, m_axi_arprot}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // Basic write/read with the one-cycle-ready slave
    do_cmd(1'b1, 6'h08, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 4, 0);
    do_cmd(1'b0, 6'h08, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF, 4, 0);

    // Partial strobe
    do_cmd(1'b1, 6'h08, 32'h000000AA, 4'h1, 2'b00, 32'h0, 4, 0);
    do_cmd(1'b0, 6'h08, 32'h0, 4'h0, 2'b00, 32'hDEADBEAA, 4, 0);

    // W before AW, with an early bvalid that must wait
    b0 = b_cnt; aw_dly = 3; w_dly = 0; b_early = 1'b1;
    do_cmd(1'b1, 6'h10, 32'h11223344, 4'hF, 2'b00, 32'h0, 0, 0);
    chk("one_b_wfirst", b_cnt - b0, 1);
    // AW before W, slave returns DECERR
    b0 = b_cnt; aw_dly = 0; w_dly = 3; b_early = 1'b0; b_resp_f = 2'b11;
    do_cmd(1'b1, 6'h14, 32'h55667788, 4'hF, 2'b11, 32'h0, 0, 0);
    chk("one_b_awfirst", b_cnt - b0, 1);
    aw_dly = 1; w_dly = 1; b_resp_f = 2'b00;
    do_cmd(1'b0, 6'h10, 32'h0, 4'h0, 2'b00, 32'h11223344, 4, 0);
    do_cmd(1'b0, 6'h14, 32'h0, 4'h0, 2'b00, 32'h55667788, 4, 0);

    // Response back-pressure; stray command during the stall must not land
    do_cmd(1'b0, 6'h08, 32'h0, 4'h0, 2'b00, 32'hDEADBEAA, 4, 5);
    do_cmd(1'b0, 6'h20, 32'h0, 4'h0, 2'b00, 32'h0, 4, 0);

    // Slave error on read
    r_force = 1'b1; r_resp_f = 2'b10; r_data_f = 32'h12345678;
    do_cmd(1'b0, 6'h0C, 32'h0, 4'h0, 2'b10, 32'h12345678, 4, 0);
    r_force = 1'b0;

    // Reset in the middle of a write the slave never accepts
    aw_dly = 1000; w_dly = 1000;
    cmd_write = 1'b1; cmd_addr = 6'h04; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_awvalid_up", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valids", {m_axi_awvalid, m_axi_wvalid, rsp_valid}, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    aw_dly = 1; w_dly = 1;
    @(negedge clk);
    chk("mid_rel_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", rsp_valid, 0);
    end
    do_cmd(1'b0, 6'h04, 32'h0, 4'h0, 2'b00, 32'h0, 4, 0);
    do_cmd(1'b0, 6'h08, 32'h0, 4'h0, 2'b00, 32'hDEADBEAA, 4, 0);

    chk("protocol_violations", viol, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
